// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared defaults and helpers for the multi-port register file.
//            win_port() resolves which write port owns an address in a
//            given cycle. The storage update, the read bypass and the
//            conflict detector all use it, so they resolve priority the
//            same way (highest index wins).
// Macro    : none
// Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

  localparam int c_DATA_W_DEF  = 32;
  localparam int c_ADDR_W_DEF  = 5;
  localparam int c_TAP_REG_DEF = 16;
  localparam int c_REG_ZERO    = 0;
  // Width of the port-hit vectors handed to win_port(); bounds NWR.
  localparam int c_MAX_WR      = 32;

  // Returns the highest set index of hits, or -1 when no port matches.
  function automatic int win_port(input logic [c_MAX_WR-1:0] hits);
    int w;
    w = -1;
    for (int p = 0; p < c_MAX_WR; p++) begin
      if (hits[p]) w = p;
    end
    return w;
  endfunction

endpackage
`default_nettype wire

// File: rtl/regfile_mp_if.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp_if
// Purpose  : Bundle of decode/writeback-side signals of regfile_mp.
//            master = pipeline side, slave = register file.
// Signals  : rd_addr/rd_data/rd_busy  read ports (slice k = port k)
//            wr_en/wr_addr/wr_data    write ports (higher index wins)
//            sb_set/sb_addr           scoreboard pending-bit set
//            tap                      registered LED debug tap
//            wr_conflict              registered same-address write pulse
// Macro    : none
// Revision : 1.0  initial release
// ============================================================================
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NRD    = 2,
  parameter int NWR    = 2,
  parameter int TAP_W  = 8
);
  logic [NRD*ADDR_W-1:0] rd_addr;
  logic [NRD*DATA_W-1:0] rd_data;
  logic [NRD-1:0]        rd_busy;
  logic [NWR-1:0]        wr_en;
  logic [NWR*ADDR_W-1:0] wr_addr;
  logic [NWR*DATA_W-1:0] wr_data;
  logic                  sb_set;
  logic [ADDR_W-1:0]     sb_addr;
  logic [TAP_W-1:0]      tap;
  logic                  wr_conflict;

  modport master (
    output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    input  rd_data, rd_busy, tap, wr_conflict
  );

  modport slave (
    input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr,
    output rd_data, rd_busy, tap, wr_conflict
  );
endinterface
`default_nettype wire

// File: rtl/rf_read_port.sv
`default_nettype none
// ============================================================================
// Module   : rf_read_port
// Purpose  : One combinational read port: register-0 zero check, optional
//            same-cycle write bypass, pending-bit lookup.
// Ports    : i_reset    suppresses bypass while high
//            i_addr     read address
//            i_rf       stored register contents
//            i_pend     per-register pending bits
//            i_wr_*     write-port bus (bypass source)
//            o_data     read data
//            o_busy     pending bit of i_addr (pre-edge state)
// Macro    : RF_BYPASS_EN enables the write-to-read bypass
// Revision : 1.0  initial release
// ============================================================================
module rf_read_port
  import regfile_pkg::*;
#(
  parameter int DATA_W = c_DATA_W_DEF,
  parameter int ADDR_W = c_ADDR_W_DEF,
  parameter int NWR    = 2
) (
  input  wire logic                  i_reset,
  input  wire logic [ADDR_W-1:0]     i_addr,
  input  wire logic [DATA_W-1:0]     i_rf [1<<ADDR_W],
  input  wire logic [(1<<ADDR_W)-1:0] i_pend,
  input  wire logic [NWR-1:0]        i_wr_en,
  input  wire logic [NWR*ADDR_W-1:0] i_wr_addr,
  input  wire logic [NWR*DATA_W-1:0] i_wr_data,
  output logic      [DATA_W-1:0]     o_data,
  output logic                       o_busy
);

  logic w_is_zero;
  assign w_is_zero = (i_addr == ADDR_W'(c_REG_ZERO));

`ifdef RF_BYPASS_EN
  logic [c_MAX_WR-1:0] w_hits;
  int                  w_win;

  always_comb begin
    w_hits = '0;
    for (int p = 0; p < NWR; p++) begin
      w_hits[p] = i_wr_en[p] && (i_wr_addr[p*ADDR_W +: ADDR_W] == i_addr);
    end
    w_win = win_port(w_hits);
  end

  always_comb begin
    o_data = i_rf[i_addr];
    if (w_is_zero) begin
      o_data = '0;
    end else if (!i_reset && (w_win >= 0)) begin
      o_data = i_wr_data[w_win*DATA_W +: DATA_W];
    end
  end
`else
  logic w_unused_wr;
  assign w_unused_wr = ^{i_reset, i_wr_en, i_wr_addr, i_wr_data};

  always_comb begin
    o_data = i_rf[i_addr];
    if (w_is_zero) o_data = '0;
  end
`endif

  assign o_busy = w_is_zero ? 1'b0 : i_pend[i_addr];

endmodule
`default_nettype wire

// File: rtl/regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : regfile_mp
// Purpose  : Parametrised NRD-read / NWR-write register file with pending
//            scoreboard, registered debug tap and write-conflict flag.
//            Register 0 is hard-wired zero.
// Ports    : clk    rising-edge clock
//            reset  synchronous active-high reset
//            bus    regfile_mp_if slave (reads, writes, scoreboard, tap,
//                   wr_conflict)
// Macro    : RF_BYPASS_EN enables same-cycle write-to-read bypass
// Revision : 1.0  initial release
// ============================================================================
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int DATA_W  = c_DATA_W_DEF,
  parameter int ADDR_W  = c_ADDR_W_DEF,
  parameter int NRD     = 2,
  parameter int NWR     = 2,
  parameter int TAP_REG = c_TAP_REG_DEF,
  parameter int TAP_W   = 8
) (
  input wire logic   clk,
  input wire logic   reset,
  regfile_mp_if.slave bus
);

  localparam int c_DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0]   r_rf       [c_DEPTH];
  logic [DATA_W-1:0]   w_rf_nxt   [c_DEPTH];
  logic [c_MAX_WR-1:0] w_hits     [c_DEPTH];
  int                  w_win      [c_DEPTH];
  logic [c_DEPTH-1:0]  r_pend;
  logic [c_DEPTH-1:0]  w_pend_nxt;
  logic [c_DEPTH-1:0]  w_wr_hit;
  logic                w_conflict;
  logic [TAP_W-1:0]    r_tap;
  logic                r_conflict;

  logic [NRD*DATA_W-1:0] w_rd_data;
  logic [NRD-1:0]        w_rd_busy;

  // Per-address write resolution. Address 0 is never matched, so it keeps
  // its reset value of zero and never takes part in a conflict.
  always_comb begin
    w_rf_nxt   = r_rf;
    w_wr_hit   = '0;
    w_conflict = 1'b0;
    for (int a = 0; a < c_DEPTH; a++) begin
      w_hits[a] = '0;
      w_win[a]  = -1;
    end
    for (int a = 1; a < c_DEPTH; a++) begin
      for (int p = 0; p < NWR; p++) begin
        w_hits[a][p] = bus.wr_en[p] &&
                       (bus.wr_addr[p*ADDR_W +: ADDR_W] == ADDR_W'(a));
      end
      w_win[a] = win_port(w_hits[a]);
      if (w_win[a] >= 0) begin
        w_rf_nxt[a] = bus.wr_data[w_win[a]*DATA_W +: DATA_W];
        w_wr_hit[a] = 1'b1;
      end
      // More than one bit set in the hit vector means a same-address clash.
      if ((w_hits[a] & (w_hits[a] - 1'b1)) != '0) w_conflict = 1'b1;
    end
  end

  // Clears are applied first so a same-cycle set for a newer producer wins.
  always_comb begin
    w_pend_nxt = r_pend & ~w_wr_hit;
    if (bus.sb_set && (bus.sb_addr != ADDR_W'(c_REG_ZERO))) begin
      w_pend_nxt[bus.sb_addr] = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int a = 0; a < c_DEPTH; a++) r_rf[a] <= '0;
      r_pend     <= '0;
      r_tap      <= '0;
      r_conflict <= 1'b0;
    end else begin
      r_rf       <= w_rf_nxt;
      r_pend     <= w_pend_nxt;
      // Taken from the next-state value so the tap tracks the write edge.
      r_tap      <= w_rf_nxt[TAP_REG][TAP_W-1:0];
      r_conflict <= w_conflict;
    end
  end

  for (genvar k = 0; k < NRD; k++) begin : g_rd
    rf_read_port #(
      .DATA_W (DATA_W),
      .ADDR_W (ADDR_W),
      .NWR    (NWR)
    ) u_port (
      .i_reset   (reset),
      .i_addr    (bus.rd_addr[k*ADDR_W +: ADDR_W]),
      .i_rf      (r_rf),
      .i_pend    (r_pend),
      .i_wr_en   (bus.wr_en),
      .i_wr_addr (bus.wr_addr),
      .i_wr_data (bus.wr_data),
      .o_data    (w_rd_data[k*DATA_W +: DATA_W]),
      .o_busy    (w_rd_busy[k])
    );
  end

  assign bus.rd_data     = w_rd_data;
  assign bus.rd_busy     = w_rd_busy;
  assign bus.tap         = r_tap;
  assign bus.wr_conflict = r_conflict;

endmodule
`default_nettype wire

// File: tb/tb_regfile_mp.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_mp
// Purpose  : Scoreboard bench for regfile_mp (2 read / 2 write ports).
//            Stimulus drives inputs 1 time unit after each rising edge and
//            queues the expected values for that cycle; the monitor samples
//            on the falling edge and compares.
// Macro    : RF_BYPASS_EN selects the bypass expectations
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_mp;

  localparam int c_DW = 32;
  localparam int c_AW = 5;

  // Observed quantities.
  localparam int c_K_RD0  = 0;
  localparam int c_K_RD1  = 1;
  localparam int c_K_BSY0 = 2;
  localparam int c_K_BSY1 = 3;
  localparam int c_K_TAP  = 4;
  localparam int c_K_CFL  = 5;

  typedef struct {
    int          cyc;
    int          kind;
    logic [31:0] exp;
    string       name;
  } exp_t;

  logic clk;
  logic reset;
  int   cyc;
  int   total;
  int   bad;
  exp_t sbq[$];

  regfile_mp_if #(.DATA_W(c_DW), .ADDR_W(c_AW), .NRD(2), .NWR(2), .TAP_W(8)) bus ();

  regfile_mp #(
    .DATA_W (c_DW),
    .ADDR_W (c_AW),
    .NRD    (2),
    .NWR    (2),
    .TAP_REG(16),
    .TAP_W  (8)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] observe(input int kind);
    case (kind)
      c_K_RD0:  return bus.rd_data[31:0];
      c_K_RD1:  return bus.rd_data[63:32];
      c_K_BSY0: return {31'b0, bus.rd_busy[0]};
      c_K_BSY1: return {31'b0, bus.rd_busy[1]};
      c_K_TAP:  return {24'b0, bus.tap};
      default:  return {31'b0, bus.wr_conflict};
    endcase
  endfunction

  task automatic expect_val(input int kind, input logic [31:0] exp, input string name);
    exp_t e;
    e.cyc  = cyc;
    e.kind = kind;
    e.exp  = exp;
    e.name = name;
    sbq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    bus.wr_en   = '0;
    bus.wr_addr = '0;
    bus.wr_data = '0;
    bus.sb_set  = 1'b0;
    bus.sb_addr = '0;
  endtask

  task automatic write1(input int port, input logic [4:0] a, input logic [31:0] d);
    bus.wr_en[port]             = 1'b1;
    bus.wr_addr[port*c_AW +: c_AW] = a;
    bus.wr_data[port*c_DW +: c_DW] = d;
  endtask

  // Monitor: pops every expectation due in the current cycle.
  initial begin
    exp_t        e;
    logic [31:0] act;
    total = 0;
    bad   = 0;
    forever begin
      @(negedge clk);
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
        e   = sbq.pop_front();
        act = observe(e.kind);
        total++;
        if (e.cyc != cyc || act !== e.exp) begin
          bad++;
          $display("FAIL %s: got %h want %h (cycle %0d)", e.name, act, e.exp, cyc);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not reach the end");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] byp_val;
    reset       = 1'b1;
    bus.rd_addr = '0;
    idle_inputs();
    step();
    step();
    reset = 1'b0;

    // Reset state on every address of both ports.
    expect_val(c_K_TAP, 32'h0, "reset_tap");
    expect_val(c_K_CFL, 32'h0, "reset_conflict");
    for (int a = 0; a < 32; a++) begin
      bus.rd_addr = {5'(31 - a), 5'(a)};
      expect_val(c_K_RD0,  32'h0, "reset_rd0");
      expect_val(c_K_RD1,  32'h0, "reset_rd1");
      expect_val(c_K_BSY0, 32'h0, "reset_busy0");
      expect_val(c_K_BSY1, 32'h0, "reset_busy1");
      step();
    end

    // Single write, same-cycle read then next-cycle read.
    bus.rd_addr = {5'd0, 5'd5};
    write1(0, 5'd5, 32'h1234_5678);
`ifdef RF_BYPASS_EN
    byp_val = 32'h1234_5678;
`else
    byp_val = 32'h0;
`endif
    expect_val(c_K_RD0, byp_val, "wr5_same_cycle");
    step();
    idle_inputs();
    expect_val(c_K_RD0, 32'h1234_5678, "wr5_next_cycle");
    step();

    // Two ports to address 9: port 1 wins, conflict pulses once.
    bus.rd_addr = {5'd5, 5'd9};
    write1(0, 5'd9, 32'hAAAA_AAAA);
    write1(1, 5'd9, 32'h5555_5555);
`ifdef RF_BYPASS_EN
    byp_val = 32'h5555_5555;
`else
    byp_val = 32'h0;
`endif
    expect_val(c_K_RD0, byp_val, "wr9_same_cycle");
    expect_val(c_K_RD1, 32'h1234_5678, "rd5_other_port");
    expect_val(c_K_CFL, 32'h0, "conflict_before");
    step();
    idle_inputs();
    expect_val(c_K_RD0, 32'h5555_5555, "wr9_priority");
    expect_val(c_K_CFL, 32'h1, "conflict_pulse");
    step();
    expect_val(c_K_CFL, 32'h0, "conflict_one_cycle");

    // Both ports to address 0: discarded, no conflict.
    bus.rd_addr = {5'd9, 5'd0};
    write1(0, 5'd0, 32'hDEAD_BEEF);
    write1(1, 5'd0, 32'hCAFE_F00D);
    expect_val(c_K_RD0, 32'h0, "wr0_same_cycle");
    step();
    idle_inputs();
    expect_val(c_K_RD0, 32'h0, "wr0_stays_zero");
    expect_val(c_K_CFL, 32'h0, "wr0_no_conflict");
    expect_val(c_K_RD1, 32'h5555_5555, "rd9_kept");
    step();

    // Scoreboard set, then clear by a write.
    bus.rd_addr = {5'd7, 5'd0};
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd7;
    expect_val(c_K_BSY1, 32'h0, "sb_set_pre_edge");
    step();
    idle_inputs();
    expect_val(c_K_BSY1, 32'h1, "sb_set_busy");
    step();
    write1(0, 5'd7, 32'h0000_0077);
    expect_val(c_K_BSY1, 32'h1, "sb_clear_pre_edge");
    step();
    idle_inputs();
    expect_val(c_K_BSY1, 32'h0, "sb_clear_busy");
    expect_val(c_K_RD1, 32'h0000_0077, "rd7_value");
    step();

    // Set and write to the same address in one cycle: set wins.
    write1(1, 5'd7, 32'h0000_0777);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd7;
    step();
    idle_inputs();
    expect_val(c_K_BSY1, 32'h1, "sb_set_beats_clear");
    expect_val(c_K_RD1, 32'h0000_0777, "rd7_rewritten");
    step();

    // sb_addr 0 is ignored.
    bus.rd_addr = {5'd7, 5'd0};
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd0;
    step();
    idle_inputs();
    expect_val(c_K_BSY0, 32'h0, "sb_addr0_ignored");
    step();

    // Tap follows register 16 one cycle after the write edge.
    bus.rd_addr = {5'd7, 5'd16};
    write1(0, 5'd16, 32'h0000_00C3);
    expect_val(c_K_TAP, 32'h0, "tap_before");
    step();
    idle_inputs();
    expect_val(c_K_TAP, 32'h0000_00C3, "tap_after");
    expect_val(c_K_RD0, 32'h0000_00C3, "rd16_value");
    step();

    // Reset with a concurrent write and sb_set: bypass suppressed, all cleared.
    reset = 1'b1;
    write1(1, 5'd16, 32'h0000_00FF);
    bus.sb_set  = 1'b1;
    bus.sb_addr = 5'd7;
    expect_val(c_K_RD0,  32'h0000_00C3, "reset_no_bypass");
    expect_val(c_K_BSY1, 32'h1, "busy7_before_reset");
    expect_val(c_K_TAP,  32'h0000_00C3, "tap_before_reset");
    step();
    reset = 1'b0;
    idle_inputs();
    expect_val(c_K_TAP,  32'h0, "tap_after_reset");
    expect_val(c_K_RD0,  32'h0, "rd16_after_reset");
    expect_val(c_K_BSY1, 32'h0, "busy7_after_reset");
    expect_val(c_K_RD1,  32'h0, "rd7_after_reset");
    step();
    step();
    step();

    if (sbq.size() != 0) begin
      $display("FAIL drain: got %0d pending want 0", sbq.size());
      bad = bad + sbq.size();
      total = total + sbq.size();
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
